icache: RTL and testbench

Direct-mapped, read-only instruction cache. It returns one DATA_BITWIDTH instruction per fetch request. On a miss it refills a whole cache line with one read burst from the burst-RAM controller. It sits between the instruction-port arbiter (which drives enable/address and watches busy/data_ready) and the shared burst-RAM controller (br_* signals).

---
 rtl/icache_pkg.sv | 35 +++
 rtl/icache_line_store.sv | 68 ++++++
 rtl/icache.sv | 173 +++++++++++++++++
 tb/tb_icache.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : icache_pkg
// Description : Derived geometry helpers and refill FSM encoding for icache.
// Revision    : 1.0
// ============================================================================
package icache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_RECV = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic int byte_off_bitwidth(input int data_bitwidth);
        return $clog2(data_bitwidth / 8);
    endfunction

    function automatic int tag_bitwidth(input int addr_bitwidth, input int line_ix_bitwidth,
                                        input int data_ix_bitwidth, input int data_bitwidth);
        return addr_bitwidth - line_ix_bitwidth - data_ix_bitwidth
               - byte_off_bitwidth(data_bitwidth);
    endfunction

    function automatic int words_per_beat(input int beat_bitwidth, input int data_bitwidth);
        return beat_bitwidth / data_bitwidth;
    endfunction

    function automatic int beat_cnt_bitwidth(input int beat_count);
        return (beat_count > 1) ? $clog2(beat_count) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/icache_line_store.sv
`default_nettype none
// ============================================================================
// Module      : icache_line_store
// Description : Tag/valid/data array; combinational lookup and fill read
//               ports, beat-wide refill write port, tag commit port.
// Revision    : 1.0
// ============================================================================
module icache_line_store #(
    parameter int LINE_IX_BITWIDTH = 1,
    parameter int WORD_IX_BITWIDTH = 3,
    parameter int TAG_BITWIDTH     = 26,
    parameter int DATA_BITWIDTH    = 32,
    parameter int BEAT_IX_BITWIDTH = 2,
    parameter int WORDS_PER_BEAT   = 2
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [LINE_IX_BITWIDTH-1:0]             lookup_line,
    input  logic [WORD_IX_BITWIDTH-1:0]             lookup_word,
    output logic                                    lookup_valid,
    output logic [TAG_BITWIDTH-1:0]                 lookup_tag,
    output logic [DATA_BITWIDTH-1:0]                lookup_data,
    input  logic [LINE_IX_BITWIDTH-1:0]             fill_line,
    input  logic [WORD_IX_BITWIDTH-1:0]             fill_word,
    output logic [DATA_BITWIDTH-1:0]                fill_data,
    input  logic                                    fill_wr_en,
    input  logic [BEAT_IX_BITWIDTH-1:0]             fill_beat,
    input  logic [WORDS_PER_BEAT*DATA_BITWIDTH-1:0] fill_wr_data,
    input  logic                                    fill_commit,
    input  logic [TAG_BITWIDTH-1:0]                 fill_tag
);

    localparam int c_lines = 2 ** LINE_IX_BITWIDTH;
    localparam int c_words = 2 ** WORD_IX_BITWIDTH;

    logic [c_lines-1:0]      r_valid;
    logic [TAG_BITWIDTH-1:0] r_tag  [c_lines];
    logic [DATA_BITWIDTH-1:0] r_word [c_lines*c_words];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            for (int i = 0; i < c_lines; i++) begin
                r_tag[i] <= '0;
            end
        end else if (fill_commit) begin
            r_valid[fill_line] <= 1'b1;
            r_tag[fill_line]   <= fill_tag;
        end
    end

    // Low bits of a beat land in the lower-addressed word.
    always_ff @(posedge clk) begin
        if (fill_wr_en) begin
            for (int j = 0; j < WORDS_PER_BEAT; j++) begin
                r_word[{fill_line, WORD_IX_BITWIDTH'(int'(fill_beat) * WORDS_PER_BEAT + j)}]
                    <= fill_wr_data[j*DATA_BITWIDTH +: DATA_BITWIDTH];
            end
        end
    end

    assign lookup_valid = r_valid[lookup_line];
    assign lookup_tag   = r_tag[lookup_line];
    assign lookup_data  = r_word[{lookup_line, lookup_word}];
    assign fill_data    = r_word[{fill_line, fill_word}];

endmodule
`default_nettype wire

// File: rtl/icache.sv
`default_nettype none
// ============================================================================
// Module      : icache
// Description : Direct-mapped read-only instruction cache with whole-line
//               burst refill from the burst-RAM controller.
// Revision    : 1.0
// ============================================================================
module icache
    import icache_pkg::*;
#(
    parameter int ADDRESS_BITWIDTH         = 32,
    parameter int LINE_IX_BITWIDTH         = 1,
    parameter int DATA_BITWIDTH            = 32,
    parameter int DATA_IX_IN_LINE_BITWIDTH = 3,
    parameter int RAM_DEPTH_BITWIDTH       = 4,
    parameter int RAM_BURST_DATA_BITWIDTH  = 64,
    parameter int RAM_BURST_DATA_COUNT     = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               enable,
    input  logic [ADDRESS_BITWIDTH-1:0]        address,
    output logic [DATA_BITWIDTH-1:0]           data,
    output logic                               data_ready,
    output logic                               busy,
    output logic                               br_cmd,
    output logic                               br_cmd_en,
    output logic [RAM_DEPTH_BITWIDTH-1:0]      br_addr,
    input  logic [RAM_BURST_DATA_BITWIDTH-1:0] br_rd_data,
    input  logic                               br_rd_data_valid,
    input  logic                               br_busy
);

    localparam int c_off_bw        = byte_off_bitwidth(DATA_BITWIDTH);
    localparam int c_tag_bw        = tag_bitwidth(ADDRESS_BITWIDTH, LINE_IX_BITWIDTH,
                                                  DATA_IX_IN_LINE_BITWIDTH, DATA_BITWIDTH);
    localparam int c_words_per_beat = words_per_beat(RAM_BURST_DATA_BITWIDTH, DATA_BITWIDTH);
    localparam int c_beat_cnt_bw   = beat_cnt_bitwidth(RAM_BURST_DATA_COUNT);
    localparam int c_ram_shift     = $clog2(RAM_BURST_DATA_BITWIDTH / 8);
    localparam int c_req_bw        = ADDRESS_BITWIDTH - c_off_bw;
    localparam int c_line_base_lsbs = c_off_bw + DATA_IX_IN_LINE_BITWIDTH;
    localparam int c_dix           = DATA_IX_IN_LINE_BITWIDTH;
    localparam logic [c_beat_cnt_bw-1:0] c_last_beat = c_beat_cnt_bw'(RAM_BURST_DATA_COUNT - 1);

    state_t                     r_state;
    state_t                     w_state_next;
    logic [c_req_bw-1:0]        r_req;
    logic [c_beat_cnt_bw-1:0]   r_beat;
    logic [DATA_BITWIDTH-1:0]   r_data;
    logic                       r_hit_ready;

    logic [c_req_bw-1:0]        w_in_req;
    logic                       w_look_valid;
    logic [c_tag_bw-1:0]        w_look_tag;
    logic [DATA_BITWIDTH-1:0]   w_look_data;
    logic [DATA_BITWIDTH-1:0]   w_fill_data;
    logic                       w_accepting;
    logic                       w_hit;
    logic                       w_hit_accept;
    logic                       w_miss_accept;
    logic                       w_fill_wr;
    logic                       w_fill_commit;
    logic [ADDRESS_BITWIDTH-1:0] w_line_base;

    generate
        if (c_off_bw > 0) begin : g_byte_off
            logic [c_off_bw-1:0] w_unused_byte_off;
            assign w_unused_byte_off = address[c_off_bw-1:0];
        end
    endgenerate

    // Request kept as a word address: {tag, line, word}.
    assign w_in_req = address[ADDRESS_BITWIDTH-1:c_off_bw];

    icache_line_store #(
        .LINE_IX_BITWIDTH (LINE_IX_BITWIDTH),
        .WORD_IX_BITWIDTH (DATA_IX_IN_LINE_BITWIDTH),
        .TAG_BITWIDTH     (c_tag_bw),
        .DATA_BITWIDTH    (DATA_BITWIDTH),
        .BEAT_IX_BITWIDTH (c_beat_cnt_bw),
        .WORDS_PER_BEAT   (c_words_per_beat)
    ) u_line_store (
        .clk          (clk),
        .rst          (rst),
        .lookup_line  (w_in_req[c_dix +: LINE_IX_BITWIDTH]),
        .lookup_word  (w_in_req[c_dix-1:0]),
        .lookup_valid (w_look_valid),
        .lookup_tag   (w_look_tag),
        .lookup_data  (w_look_data),
        .fill_line    (r_req[c_dix +: LINE_IX_BITWIDTH]),
        .fill_word    (r_req[c_dix-1:0]),
        .fill_data    (w_fill_data),
        .fill_wr_en   (w_fill_wr),
        .fill_beat    (r_beat),
        .fill_wr_data (br_rd_data),
        .fill_commit  (w_fill_commit),
        .fill_tag     (r_req[c_dix+LINE_IX_BITWIDTH +: c_tag_bw])
    );

    // DONE is the data_ready cycle of a refill, so it accepts requests like IDLE.
    assign w_accepting   = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_hit         = w_look_valid && (w_look_tag == w_in_req[c_dix+LINE_IX_BITWIDTH +: c_tag_bw]);
    assign w_hit_accept  = w_accepting && enable && w_hit;
    assign w_miss_accept = w_accepting && enable && !w_hit;

    always_comb begin
        w_state_next  = r_state;
        br_cmd_en     = 1'b0;
        w_fill_wr     = 1'b0;
        w_fill_commit = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_miss_accept) begin
                    w_state_next = ST_SEND;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (!br_busy) begin
                    br_cmd_en    = 1'b1;
                    w_state_next = ST_RECV;
                end
            end
            ST_RECV: begin
                if (br_rd_data_valid) begin
                    w_fill_wr = 1'b1;
                    if (r_beat == c_last_beat) begin
                        w_fill_commit = 1'b1;
                        w_state_next  = ST_DONE;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_req       <= '0;
            r_beat      <= '0;
            r_data      <= '0;
            r_hit_ready <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_hit_ready <= w_hit_accept;
            if (w_miss_accept) begin
                r_req  <= w_in_req;
                r_beat <= '0;
            end
            if (w_fill_wr) begin
                r_beat <= r_beat + c_beat_cnt_bw'(1);
            end
            if (r_state == ST_DONE) begin
                r_data <= w_fill_data;
            end
            if (w_hit_accept) begin
                r_data <= w_look_data;
            end
        end
    end

    assign w_line_base = {r_req[c_req_bw-1:c_dix], {c_line_base_lsbs{1'b0}}};

    assign br_cmd     = 1'b0;
    assign br_addr    = RAM_DEPTH_BITWIDTH'(w_line_base >> c_ram_shift);
    assign busy       = (r_state == ST_SEND) || (r_state == ST_RECV);
    assign data_ready = r_hit_ready || (r_state == ST_DONE);
    assign data       = (r_state == ST_DONE) ? w_fill_data : r_data;

endmodule
`default_nettype wire

// File: tb/tb_icache.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache
// Description : Self-checking bench for icache with a burst-RAM responder and
//               an address-level cache model.
// Revision    : 1.0
// ============================================================================
module tb_icache;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [31:0] address;
    logic [31:0] data;
    logic        data_ready;
    logic        busy;
    logic        br_cmd;
    logic        br_cmd_en;
    logic [3:0]  br_addr;
    logic [63:0] br_rd_data;
    logic        br_rd_data_valid;
    logic        br_busy;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc_count = 0;
    int cmd_count = 0;
    int overlap_count = 0;
    int beats_done = 0;
    int last_beat_cyc = 0;
    bit ram_active = 1'b0;
    logic [3:0] last_addr = '0;
    logic       last_cmd = 1'b0;

    bit          m_valid [2];
    logic [25:0] m_tag   [2];

    icache dut (
        .clk              (clk),
        .rst              (rst),
        .enable           (enable),
        .address          (address),
        .data             (data),
        .data_ready       (data_ready),
        .busy             (busy),
        .br_cmd           (br_cmd),
        .br_cmd_en        (br_cmd_en),
        .br_addr          (br_addr),
        .br_rd_data       (br_rd_data),
        .br_rd_data_valid (br_rd_data_valid),
        .br_busy          (br_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_count <= cyc_count + 1;

    always @(negedge clk) begin
        if (br_cmd_en === 1'b1) begin
            cmd_count = cmd_count + 1;
            last_addr = br_addr;
            last_cmd  = br_cmd;
        end
        if (data_ready === 1'b1 && busy === 1'b1) overlap_count = overlap_count + 1;
    end

    // The backing RAM holds instruction n at byte address 4n (128 B window).
    initial begin
        int base;
        br_rd_data_valid = 1'b0;
        br_rd_data       = '0;
        forever begin
            @(negedge clk);
            if (br_cmd_en === 1'b1 && rst === 1'b0) begin
                base       = int'(br_addr);
                ram_active = 1'b1;
                beats_done = 0;
                @(posedge clk);
                for (int k = 0; k < 4; k++) begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                    br_rd_data_valid = 1'b1;
                    br_rd_data = {32'(2 * (base + k) + 1), 32'(2 * (base + k))};
                    @(posedge clk);
                    #1;
                    br_rd_data_valid = 1'b0;
                    br_rd_data = {$urandom, $urandom};
                    beats_done = beats_done + 1;
                    if (k == 3) last_beat_cyc = cyc_count;
                end
                ram_active = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] exp_instr(input logic [31:0] a);
        return (a % 128) / 4;
    endfunction

    function automatic logic [3:0] exp_br_addr(input logic [31:0] a);
        return 4'(((a / 32) * 4) % 16);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_ready"}, data_ready, 0);
        check({tag, "_data"}, data, 0);
        check({tag, "_cmd_en"}, br_cmd_en, 0);
        check({tag, "_cmd"}, br_cmd, 0);
        check({tag, "_br_addr"}, br_addr, 0);
    endtask

    // One fetch; hold>0 keeps br_busy high for that many cycles after a miss is taken.
    task automatic do_fetch(input logic [31:0] a, input int hold);
        bit   exp_hit;
        int   line;
        int   cmds0;
        int   cyc;
        line    = int'((a / 32) % 2);
        exp_hit = m_valid[line] && (m_tag[line] == 26'(a / 64));
        cmds0   = cmd_count;
        @(posedge clk); #1;
        enable  = 1'b1;
        address = a;
        if (!exp_hit && hold > 0) br_busy = 1'b1;
        @(posedge clk); #1;
        enable  = 1'b0;
        address = $urandom;
        @(negedge clk);
        if (exp_hit) begin
            check("hit_ready", data_ready, 1);
            check("hit_busy", busy, 0);
            check("hit_data", data, exp_instr(a));
            check("hit_no_cmd", cmd_count, cmds0);
        end else begin
            check("miss_busy", busy, 1);
            check("miss_ready", data_ready, 0);
            check("miss_cmd_now", br_cmd_en, (hold == 0));
            for (int i = 2; i <= hold; i++) begin
                @(posedge clk); #1;
                if (i == 2) begin
                    enable  = 1'b1;
                    address = a + 32'h80;
                end else begin
                    enable = 1'b0;
                end
                @(negedge clk);
                check("hold_cmd_en", br_cmd_en, 0);
                check("hold_busy", busy, 1);
            end
            if (hold > 0) begin
                @(posedge clk); #1;
                enable  = 1'b0;
                br_busy = 1'b0;
            end
            cyc = 0;
            while (data_ready !== 1'b1 && cyc < 200) begin
                @(negedge clk);
                cyc++;
            end
            check("miss_timeout", (cyc < 200), 1);
            check("miss_data", data, exp_instr(a));
            check("miss_done_busy", busy, 0);
            check("miss_ready_latency", cyc_count, last_beat_cyc);
            check("miss_cmd_count", cmd_count, cmds0 + 1);
            check("miss_br_addr", last_addr, exp_br_addr(a));
            check("miss_br_cmd", last_cmd, 0);
            m_valid[line] = 1'b1;
            m_tag[line]   = 26'(a / 64);
            @(posedge clk); #1;
            @(negedge clk);
            check("ready_pulse", data_ready, 0);
            check("data_held", data, exp_instr(a));
        end
    endtask

    initial begin
        logic [31:0] pool [4];
        logic [31:0] a;
        int          wait_cyc;
        rst = 1'b1; enable = 1'b0; address = '0; br_busy = 1'b0;
        m_valid[0] = 1'b0; m_valid[1] = 1'b0;
        m_tag[0] = '0; m_tag[1] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        do_fetch(32'h00, 0);
        do_fetch(32'h1C, 0);
        do_fetch(32'h24, 0);
        do_fetch(32'h00, 0);
        do_fetch(32'h40, 0);
        do_fetch(32'h00, 0);

        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            enable  = 1'b1;
            address = 32'(i * 4);
            @(negedge clk);
            if (i > 0) begin
                check("b2b_ready", data_ready, 1);
                check("b2b_data", data, 32'(i - 1));
            end
        end
        @(posedge clk); #1;
        enable = 1'b0;
        @(negedge clk);
        check("b2b_last_ready", data_ready, 1);
        check("b2b_last_data", data, 32'h7);

        do_fetch(32'h64, 3);

        @(posedge clk); #1;
        enable  = 1'b1;
        address = 32'h28;
        @(posedge clk); #1;
        enable  = 1'b0;
        wait_cyc = 0;
        while (beats_done < 2 && wait_cyc < 100) begin
            @(negedge clk);
            wait_cyc++;
        end
        check("rst_mid_timeout", (wait_cyc < 100), 1);
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        @(negedge clk);
        check_reset_outputs("rst_mid");
        @(posedge clk); #1;
        rst = 1'b0;
        m_valid[0] = 1'b0; m_valid[1] = 1'b0;
        wait_cyc = 0;
        while (ram_active && wait_cyc < 100) begin
            @(negedge clk);
            wait_cyc++;
        end
        @(negedge clk);
        check_reset_outputs("after_rst");
        do_fetch(32'h28, 0);
        do_fetch(32'h00, 0);

        pool[0] = 32'h0; pool[1] = 32'h1; pool[2] = 32'h5; pool[3] = 32'h03FF_FFFF;
        for (int n = 0; n < 40; n++) begin
            a = (pool[$urandom_range(0, 3)] << 6) | 32'($urandom_range(0, 63));
            do_fetch(a, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
        end

        check("ready_while_busy", overlap_count, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
